// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU memory-bus decoder: FSM states,
// slave selection and the data words returned on failed reads.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RAM,
        WAIT_PER,
        ERR_RSP
    } bus_state_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_PER
    } bus_sel_t;

    localparam logic [31:0] MEM_ERR_RDATA      = 32'hDEAD_BEEF;
    localparam logic [31:0] MEM_UNMAPPED_RDATA = 32'h0000_0000;

    localparam logic [3:0] RAM_REGION_DEF    = 4'h0;
    localparam logic [3:0] PERIPH_REGION_DEF = 4'hF;

    // RAM wins if both regions are configured to the same value.
    function automatic bus_sel_t decode_region(
        input logic [3:0] region,
        input logic [3:0] ram_region,
        input logic [3:0] per_region
    );
        if (region == ram_region) begin
            return SEL_RAM;
        end else if (region == per_region) begin
            return SEL_PER;
        end
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/mem_bus_decoder_timeout_cnt.sv
// Read-response watchdog: counts waiting cycles and flags the last one allowed.
module bus_timeout_cnt #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expire = enable && (count == LIMIT);

endmodule

// File: rtl/mem_bus_decoder.sv
// Address decoder and response router between the CPU memory bus and the
// RAM / peripheral slaves; tracks the single outstanding read.
module mem_bus_decoder
    import mem_bus_pkg::*;
#(
    parameter logic [3:0]  RAM_REGION    = RAM_REGION_DEF,
    parameter logic [3:0]  PERIPH_REGION = PERIPH_REGION_DEF,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        mem_cmd_valid,
    output logic        mem_cmd_ready,
    input  logic        mem_cmd_instr,
    input  logic        mem_cmd_wr,
    input  logic [31:0] mem_cmd_addr,
    input  logic [31:0] mem_cmd_wdata,
    input  logic [3:0]  mem_cmd_be,
    output logic        mem_rsp_ready,
    output logic [31:0] mem_rsp_rdata,

    output logic        ram_cmd_valid,
    input  logic        ram_cmd_ready,
    output logic        ram_cmd_wr,
    output logic [31:0] ram_cmd_addr,
    output logic [31:0] ram_cmd_wdata,
    output logic [3:0]  ram_cmd_be,
    input  logic        ram_rsp_ready,
    input  logic [31:0] ram_rsp_rdata,

    output logic        per_cmd_valid,
    input  logic        per_cmd_ready,
    output logic        per_cmd_wr,
    output logic [31:0] per_cmd_addr,
    output logic [31:0] per_cmd_wdata,
    output logic [3:0]  per_cmd_be,
    input  logic        per_rsp_ready,
    input  logic [31:0] per_rsp_rdata,

    output logic        bus_err,
    output logic [31:0] bus_err_addr
);

    bus_state_t  state, state_next;
    bus_sel_t    sel;
    logic        rd_wait, rsp_slave, expire, timeout, rsp_now;
    logic        can_accept, slave_ready, accept, rd_accept;
    logic [31:0] slave_rdata, rd_addr;
    logic        unused_instr;

    assign unused_instr = mem_cmd_instr;

    assign sel = decode_region(mem_cmd_addr[31:28], RAM_REGION, PERIPH_REGION);

    // Only the slave being waited on may answer; anything else is dropped.
    always_comb begin
        rsp_slave   = 1'b0;
        slave_rdata = '0;
        case (state)
            WAIT_RAM: begin
                rsp_slave   = ram_rsp_ready;
                slave_rdata = ram_rsp_rdata;
            end
            WAIT_PER: begin
                rsp_slave   = per_rsp_ready;
                slave_rdata = per_rsp_rdata;
            end
            default: ;
        endcase
    end

    assign rd_wait = (state == WAIT_RAM) || (state == WAIT_PER);
    assign timeout = !reset && expire && !rsp_slave;
    assign rsp_now = !reset && (rsp_slave || timeout || (state == ERR_RSP));

    assign can_accept = !reset && ((state == IDLE) || rsp_now);

    always_comb begin
        slave_ready = 1'b1;
        case (sel)
            SEL_RAM: slave_ready = ram_cmd_ready;
            SEL_PER: slave_ready = per_cmd_ready;
            default: slave_ready = 1'b1;
        endcase
    end

    assign mem_cmd_ready = can_accept && slave_ready;
    assign accept        = mem_cmd_valid && mem_cmd_ready;
    assign rd_accept     = accept && !mem_cmd_wr;

    assign ram_cmd_valid = mem_cmd_valid && can_accept && (sel == SEL_RAM);
    assign per_cmd_valid = mem_cmd_valid && can_accept && (sel == SEL_PER);

    assign ram_cmd_wr    = mem_cmd_wr;
    assign ram_cmd_addr  = mem_cmd_addr;
    assign ram_cmd_wdata = mem_cmd_wdata;
    assign ram_cmd_be    = mem_cmd_be;
    assign per_cmd_wr    = mem_cmd_wr;
    assign per_cmd_addr  = mem_cmd_addr;
    assign per_cmd_wdata = mem_cmd_wdata;
    assign per_cmd_be    = mem_cmd_be;

    always_comb begin
        mem_rsp_rdata = '0;
        if (rsp_now) begin
            if (state == ERR_RSP) begin
                mem_rsp_rdata = MEM_UNMAPPED_RDATA;
            end else if (timeout) begin
                mem_rsp_rdata = MEM_ERR_RDATA;
            end else begin
                mem_rsp_rdata = slave_rdata;
            end
        end
    end

    assign mem_rsp_ready = rsp_now;
    assign bus_err       = (accept && (sel == SEL_NONE)) || timeout;

    // A response cycle doubles as an IDLE cycle so reads can issue back to back.
    always_comb begin
        state_next = state;
        if ((state == IDLE) || rsp_now) begin
            state_next = IDLE;
            if (rd_accept) begin
                case (sel)
                    SEL_RAM: state_next = WAIT_RAM;
                    SEL_PER: state_next = WAIT_PER;
                    default: state_next = ERR_RSP;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rd_addr      <= '0;
            bus_err_addr <= '0;
        end else begin
            state <= state_next;
            if (rd_accept) begin
                rd_addr <= mem_cmd_addr;
            end
            if (accept && (sel == SEL_NONE)) begin
                bus_err_addr <= mem_cmd_addr;
            end else if (timeout) begin
                bus_err_addr <= rd_addr;
            end
        end
    end

    bus_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (rd_accept && (sel != SEL_NONE)),
        .enable (rd_wait),
        .expire (expire)
    );

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Randomised scoreboard bench for mem_bus_decoder with bench-side slave models.
module tb_mem_bus_decoder;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_cmd_valid = 1'b0, mem_cmd_ready, mem_cmd_instr = 1'b0, mem_cmd_wr = 1'b0;
    logic [31:0] mem_cmd_addr = '0, mem_cmd_wdata = '0;
    logic [3:0]  mem_cmd_be = '0;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_rdata;
    logic        ram_cmd_valid, ram_cmd_ready = 1'b0, ram_cmd_wr, ram_rsp_ready = 1'b0;
    logic [31:0] ram_cmd_addr, ram_cmd_wdata, ram_rsp_rdata = '0;
    logic [3:0]  ram_cmd_be;
    logic        per_cmd_valid, per_cmd_ready = 1'b0, per_cmd_wr, per_rsp_ready = 1'b0;
    logic [31:0] per_cmd_addr, per_cmd_wdata, per_rsp_rdata = '0;
    logic [3:0]  per_cmd_be;
    logic        bus_err;
    logic [31:0] bus_err_addr;

    mem_bus_decoder #(
        .RAM_REGION    (4'h0),
        .PERIPH_REGION (4'hF),
        .TIMEOUT       (T)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_cmd_instr (mem_cmd_instr),
        .mem_cmd_wr    (mem_cmd_wr),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_cmd_wdata (mem_cmd_wdata),
        .mem_cmd_be    (mem_cmd_be),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_rdata (mem_rsp_rdata),
        .ram_cmd_valid (ram_cmd_valid),
        .ram_cmd_ready (ram_cmd_ready),
        .ram_cmd_wr    (ram_cmd_wr),
        .ram_cmd_addr  (ram_cmd_addr),
        .ram_cmd_wdata (ram_cmd_wdata),
        .ram_cmd_be    (ram_cmd_be),
        .ram_rsp_ready (ram_rsp_ready),
        .ram_rsp_rdata (ram_rsp_rdata),
        .per_cmd_valid (per_cmd_valid),
        .per_cmd_ready (per_cmd_ready),
        .per_cmd_wr    (per_cmd_wr),
        .per_cmd_addr  (per_cmd_addr),
        .per_cmd_wdata (per_cmd_wdata),
        .per_cmd_be    (per_cmd_be),
        .per_rsp_ready (per_rsp_ready),
        .per_rsp_rdata (per_rsp_rdata),
        .bus_err       (bus_err),
        .bus_err_addr  (bus_err_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // lat: cycles from accept to the slave answering; 0 means the slave stays silent.
    typedef struct {
        logic        wr;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        logic [31:0] rdata;
    } cmd_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0, n_err = 0;
    cmd_t        cur;
    bit          cur_valid = 0, rst_req = 1, rdy_rand = 0;
    bit          out_valid = 0, out_to = 0;
    int          out_due = 0, out_slave = 0;
    logic [31:0] out_addr = '0, m_err_addr = '0;
    int          ram_fire = -1, per_fire = -1;
    logic [31:0] ram_fire_data = '0, per_fire_data = '0;

    // 0 = unmapped, 1 = RAM, 2 = peripheral
    function automatic int region(input logic [31:0] a);
        if (a[31:28] == 4'h0) return 1;
        if (a[31:28] == 4'hF) return 2;
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic cmd_t mk(input logic wr, input logic [31:0] addr, input int lat,
                                input logic [31:0] data, input logic [3:0] be);
        cmd_t c;
        c.wr = wr; c.instr = 1'b0; c.addr = addr; c.wdata = data; c.be = be;
        c.lat = lat; c.rdata = data;
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        int   r;
        r = $urandom_range(0, 9);
        c.addr = $urandom;
        if (r < 5)      c.addr[31:28] = 4'h0;
        else if (r < 8) c.addr[31:28] = 4'hF;
        else            c.addr[31:28] = 4'($urandom_range(1, 14));
        c.wr    = ($urandom_range(0, 2) == 0);
        c.instr = 1'($urandom_range(0, 1));
        c.wdata = $urandom;
        c.be    = 4'($urandom_range(0, 15));
        c.rdata = $urandom;
        c.lat   = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, T));
        return c;
    endfunction

    task automatic cycle_begin();
        @(posedge clk);
        #1;
        reset         = rst_req;
        mem_cmd_valid = cur_valid;
        mem_cmd_wr    = cur.wr;
        mem_cmd_instr = cur.instr;
        mem_cmd_addr  = cur.addr;
        mem_cmd_wdata = cur.wdata;
        mem_cmd_be    = cur.be;
        ram_cmd_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        per_cmd_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (cyc == ram_fire) begin
            ram_rsp_ready = 1'b1;
            ram_rsp_rdata = ram_fire_data;
        end else begin
            ram_rsp_ready = !(out_valid && out_slave == 1) && ($urandom_range(0, 3) == 0);
            ram_rsp_rdata = $urandom;
        end
        if (cyc == per_fire) begin
            per_rsp_ready = 1'b1;
            per_rsp_rdata = per_fire_data;
        end else begin
            per_rsp_ready = !(out_valid && out_slave == 2) && ($urandom_range(0, 3) == 0);
            per_rsp_rdata = $urandom;
        end
    endtask

    task automatic cycle_end(output bit acc);
        bit   rsp_now, can_acc, exp_ready, exp_err;
        int   sel;
        exp_t e;
        @(negedge clk);
        acc = 0;
        if (reset) begin
            check("rst_ram_cmd_valid", 32'(ram_cmd_valid), 32'd0);
            check("rst_per_cmd_valid", 32'(per_cmd_valid), 32'd0);
            check("rst_mem_rsp_ready", 32'(mem_rsp_ready), 32'd0);
            check("rst_bus_err", 32'(bus_err), 32'd0);
            out_valid = 0; q.delete(); ram_fire = -1; per_fire = -1; m_err_addr = '0;
            return;
        end
        sel       = region(cur.addr);
        rsp_now   = out_valid && (out_due == cyc);
        can_acc   = !out_valid || rsp_now;
        exp_ready = can_acc && (sel == 0 || (sel == 1 ? ram_cmd_ready : per_cmd_ready));
        check("mem_cmd_ready", 32'(mem_cmd_ready), 32'(exp_ready));
        check("ram_cmd_valid", 32'(ram_cmd_valid), 32'(cur_valid && can_acc && sel == 1));
        check("per_cmd_valid", 32'(per_cmd_valid), 32'(cur_valid && can_acc && sel == 2));
        acc     = cur_valid && exp_ready;
        exp_err = (rsp_now && out_to) || (acc && sel == 0);
        check("bus_err", 32'(bus_err), 32'(exp_err));
        check("bus_err_addr", bus_err_addr, m_err_addr);
        if (rsp_now && out_to) m_err_addr = out_addr;
        if (acc && sel == 0)   m_err_addr = cur.addr;
        if (rsp_now) out_valid = 0;
        if (acc && sel == 1) begin
            check("ram_cmd_wr", 32'(ram_cmd_wr), 32'(cur.wr));
            check("ram_cmd_addr", ram_cmd_addr, cur.addr);
            check("ram_cmd_wdata", ram_cmd_wdata, cur.wdata);
            check("ram_cmd_be", 32'(ram_cmd_be), 32'(cur.be));
        end
        if (acc && sel == 2) begin
            check("per_cmd_wr", 32'(per_cmd_wr), 32'(cur.wr));
            check("per_cmd_addr", per_cmd_addr, cur.addr);
            check("per_cmd_wdata", per_cmd_wdata, cur.wdata);
            check("per_cmd_be", 32'(per_cmd_be), 32'(cur.be));
        end
        if (acc && !cur.wr) begin
            if (sel == 0) begin
                e.data = 32'h0; e.due = cyc + 1; out_to = 0;
            end else if (cur.lat > 0 && cur.lat <= T) begin
                e.data = cur.rdata; e.due = cyc + cur.lat; out_to = 0;
            end else begin
                e.data = 32'hDEAD_BEEF; e.due = cyc + T; out_to = 1;
            end
            if (sel == 1 && cur.lat > 0) begin ram_fire = cyc + cur.lat; ram_fire_data = cur.rdata; end
            if (sel == 2 && cur.lat > 0) begin per_fire = cyc + cur.lat; per_fire_data = cur.rdata; end
            q.push_back(e);
            out_valid = 1; out_due = e.due; out_slave = sel; out_addr = cur.addr;
        end
    endtask

    task automatic run_cmd(input cmd_t c);
        bit acc;
        acc = 0;
        cur = c;
        cur_valid = 1;
        for (int i = 0; i < 60; i++) begin
            cycle_begin();
            cycle_end(acc);
            if (acc) break;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_wait at cycle %0d: got no accept, expected accept within 60 cycles", cyc);
        end
        cur_valid = 0;
    endtask

    task automatic idle(input int n);
        bit acc;
        cur_valid = 0;
        for (int i = 0; i < n; i++) begin
            cycle_begin();
            cycle_end(acc);
        end
    endtask

    task automatic do_reset(input int n);
        bit acc;
        rst_req = 1;
        cur = rand_cmd();
        cur_valid = 1;
        for (int i = 0; i < n; i++) begin
            cycle_begin();
            cycle_end(acc);
        end
        rst_req = 0;
        cur_valid = 0;
    endtask

    // Response monitor: every read response must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_rsp_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rsp_unexpected at cycle %0d: got data %h, expected no response", cyc, mem_rsp_rdata);
                end else begin
                    e = q.pop_front();
                    check("rsp_rdata", mem_rsp_rdata, e.data);
                    check("rsp_cycle", 32'(cyc), 32'(e.due));
                end
            end else begin
                check("rsp_rdata_idle", mem_rsp_rdata, 32'h0);
                if (q.size() != 0 && q[0].due < cyc) begin
                    e = q.pop_front();
                    check("rsp_missing_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    initial begin
        cur = mk(1'b0, 32'h0, 0, 32'h0, 4'h0);
        do_reset(3);
        idle(2);
        rdy_rand = 0;
        run_cmd(mk(1'b0, 32'h0000_0010, 2, 32'h1234_5678, 4'hF));
        idle(3);
        run_cmd(mk(1'b0, 32'h0000_0100, 1, 32'hCAFE_0001, 4'hF));
        run_cmd(mk(1'b0, 32'h0000_0104, 1, 32'hCAFE_0002, 4'hF));
        idle(2);
        run_cmd(mk(1'b0, 32'h5000_0000, 0, 32'h0, 4'hF));
        idle(2);
        run_cmd(mk(1'b0, 32'hF000_0008, 12, 32'h7777_7777, 4'hF));
        idle(14);
        run_cmd(mk(1'b0, 32'h0000_0020, 5, 32'h0BAD_F00D, 4'hF));
        run_cmd(mk(1'b1, 32'hF000_0004, 0, 32'hA5A5_0F0F, 4'b0101));
        idle(2);
        run_cmd(mk(1'b0, 32'h0000_0030, 5, 32'h1111_2222, 4'hF));
        idle(1);
        do_reset(1);
        idle(6);
        rdy_rand = 1;
        for (int i = 0; i < 400; i++) begin
            run_cmd(rand_cmd());
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0) break;
            idle(1);
        end
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain at cycle %0d: got %0d pending responses, expected 0", cyc, q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
